instr_encoder: RTL and testbench

Two-stage pipelined RISC-V instruction encoder: the inverse of the immediate generator. It takes a format code, register/function fields and a full 32-bit immediate, and packs them into a 32-bit instruction word. It checks that the immediate is encodable and reports violations. It sits in the debug/boot path, where it builds instructions that are injected into instruction memory. Valid/ready handshakes on both sides, throughput one word per cycle.

---
 rtl/instr_pkg.sv | 48 ++++
 rtl/instr_pack.sv | 53 +++++
 rtl/instr_encoder.sv | 87 ++++++++
 tb/tb_instr_encoder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared formats, opcodes, field widths and stage-1 field record for instr_encoder
package instr_pkg;

    localparam int xlen  = 32;
    localparam int reg_w = 5;
    localparam int opc_w = 7;
    localparam int f3_w  = 3;
    localparam int f7_w  = 7;
    localparam int fmt_w = 3;

    typedef enum logic [fmt_w-1:0] {
        fmt_r = 3'd0,
        fmt_i = 3'd1,
        fmt_s = 3'd2,
        fmt_b = 3'd3,
        fmt_u = 3'd4,
        fmt_j = 3'd5
    } fmt_t;

    localparam logic [opc_w-1:0] opc_op     = 7'b0110011;
    localparam logic [opc_w-1:0] opc_op_imm = 7'b0010011;
    localparam logic [opc_w-1:0] opc_load   = 7'b0000011;
    localparam logic [opc_w-1:0] opc_store  = 7'b0100011;
    localparam logic [opc_w-1:0] opc_branch = 7'b1100011;
    localparam logic [opc_w-1:0] opc_lui    = 7'b0110111;
    localparam logic [opc_w-1:0] opc_auipc  = 7'b0010111;
    localparam logic [opc_w-1:0] opc_jal    = 7'b1101111;
    localparam logic [opc_w-1:0] opc_jalr   = 7'b1100111;

    typedef struct packed {
        logic [fmt_w-1:0] fmt;
        logic [opc_w-1:0] opcode;
        logic [reg_w-1:0] rd;
        logic [reg_w-1:0] rs1;
        logic [reg_w-1:0] rs2;
        logic [f3_w-1:0]  funct3;
        logic [f7_w-1:0]  funct7;
        logic [xlen-1:0]  imm;
    } fields_t;

    // True when v[31:lsb] is a pure sign extension (all ones or all zeros).
    function automatic logic all_same(input logic [xlen-1:0] v, input int lsb);
        logic [xlen-1:0] m;
        m = {xlen{1'b1}} << lsb;
        return ((v & m) == m) || ((v & m) == '0);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational field packing and immediate encodability check (IMM_CHECK_EN)
module instr_pack
    import instr_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] ir,
    output logic        err
);

    logic illegal;

    always_comb begin
        ir      = '0;
        illegal = 1'b0;
        case (fmt)
            fmt_r:   ir = {funct7, rs2, rs1, funct3, rd, opcode};
            fmt_i:   ir = {imm[11:0], rs1, funct3, rd, opcode};
            fmt_s:   ir = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            fmt_b:   ir = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            fmt_u:   ir = {imm[31:12], rd, opcode};
            fmt_j:   ir = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: illegal = 1'b1;
        endcase
    end

`ifdef IMM_CHECK_EN
    logic bad_imm;

    always_comb begin
        bad_imm = 1'b0;
        case (fmt)
            fmt_i, fmt_s: bad_imm = !all_same(imm, 11);
            fmt_b:        bad_imm = !all_same(imm, 12) || imm[0];
            fmt_j:        bad_imm = !all_same(imm, 20) || imm[0];
            fmt_u:        bad_imm = (imm[11:0] != 12'd0);
            default:      bad_imm = 1'b0;
        endcase
    end

    assign err = illegal | bad_imm;
`else
    // Without checking, out-of-range immediates are simply truncated.
    assign err = illegal;
`endif

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - two-stage valid/ready RISC-V instruction encoder top (IMM_CHECK_EN)
module instr_encoder
    import instr_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       FMT,
    input  logic [6:0]       OPCODE,
    input  logic [4:0]       RD,
    input  logic [4:0]       RS1,
    input  logic [4:0]       RS2,
    input  logic [2:0]       FUNCT3,
    input  logic [6:0]       FUNCT7,
    input  logic [31:0]      IMM,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      IR,
    output logic             ERR,
    output logic [CNT_W-1:0] ERR_CNT
);

    fields_t     s1;
    logic        s1_valid;
    logic        s2_ready;
    logic [31:0] enc_ir;
    logic        enc_err;

    assign s2_ready = !OUT_VALID | OUT_READY;
    assign IN_READY = !s1_valid | s2_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (IN_READY) begin
            s1_valid <= IN_VALID;
            if (IN_VALID) begin
                s1 <= {FMT, OPCODE, RD, RS1, RS2, FUNCT3, FUNCT7, IMM};
            end
        end
    end

    instr_pack u_pack (
        .fmt    (s1.fmt),
        .opcode (s1.opcode),
        .rd     (s1.rd),
        .rs1    (s1.rs1),
        .rs2    (s1.rs2),
        .funct3 (s1.funct3),
        .funct7 (s1.funct7),
        .imm    (s1.imm),
        .ir     (enc_ir),
        .err    (enc_err)
    );

    // IR/ERR only load with a new word, so they hold while the consumer stalls.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            IR        <= '0;
            ERR       <= 1'b0;
        end else if (s2_ready) begin
            OUT_VALID <= s1_valid;
            if (s1_valid) begin
                IR  <= enc_ir;
                ERR <= enc_err;
            end
        end
    end

`ifdef IMM_CHECK_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ERR_CNT <= '0;
        end else if (OUT_VALID && OUT_READY && ERR && !(&ERR_CNT)) begin
            ERR_CNT <= ERR_CNT + CNT_W'(1);
        end
    end
`else
    assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder (model follows IMM_CHECK_EN)
module tb_instr_encoder;

    localparam int CW  = 3;
    localparam int SAT = 7;
`ifdef IMM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [2:0]    FMT = '0;
    logic [6:0]    OPCODE = '0;
    logic [4:0]    RD = '0;
    logic [4:0]    RS1 = '0;
    logic [4:0]    RS2 = '0;
    logic [2:0]    FUNCT3 = '0;
    logic [6:0]    FUNCT7 = '0;
    logic [31:0]   IMM = '0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b1;
    logic [31:0]   IR;
    logic          ERR;
    logic [CW-1:0] ERR_CNT;

    instr_encoder #(.CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .FMT(FMT), .OPCODE(OPCODE), .RD(RD), .RS1(RS1), .RS2(RS2),
        .FUNCT3(FUNCT3), .FUNCT7(FUNCT7), .IMM(IMM),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .IR(IR), .ERR(ERR), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int popped = 0;
    int cnt_m = 0;

    typedef struct {
        logic [31:0] ir;
        logic        err;
        int          acc;
    } exp_t;
    exp_t q[$];
    logic [32:0] m;
    logic        exp_ov;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoding from the format tables, using shifts and signed ranges.
    function automatic logic [32:0] model(input logic [2:0] fmt, input logic [6:0] op,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] w;
        logic [31:0] base;
        logic        bad;
        int          si;
        si   = imm;
        bad  = 1'b0;
        base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (fmt)
            3'd0: w = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
            3'd1: begin
                w   = ((imm & 32'hFFF) << 20) | base | (32'(rd) << 7);
                bad = (si < -2048) || (si > 2047);
            end
            3'd2: begin
                w   = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base | ((imm & 32'h1F) << 7);
                bad = (si < -2048) || (si > 2047);
            end
            3'd3: begin
                w   = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
                    | base | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
                bad = (si < -4096) || (si > 4095) || (imm[0] == 1'b1);
            end
            3'd4: begin
                w   = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
                bad = (imm % 4096) != 0;
            end
            3'd5: begin
                w   = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20)
                    | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'(op);
                bad = (si < -(1 << 20)) || (si > (1 << 20) - 1) || (imm[0] == 1'b1);
            end
            default: return {1'b1, 32'h0};
        endcase
        return {bad & CHK, w};
    endfunction

    // Per-cycle scoreboard: outputs checked against the in-flight word queue.
    always @(negedge CLK) begin
        if (RST) begin
            q.delete();
            cnt_m = 0;
        end else begin
            exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
            chk("out_valid", OUT_VALID, exp_ov);
            if (OUT_VALID && q.size() > 0) begin
                chk("ir", IR, q[0].ir);
                chk("err", ERR, q[0].err);
            end
            chk("err_cnt", ERR_CNT, cnt_m);
            chk("in_ready", IN_READY, (q.size() < 2) || OUT_READY);
            if (OUT_VALID && OUT_READY && q.size() > 0) begin
                if (CHK && q[0].err && cnt_m < SAT) cnt_m++;
                void'(q.pop_front());
                popped++;
            end
            if (IN_VALID && IN_READY) begin
                m = model(FMT, OPCODE, RD, RS1, RS2, FUNCT3, FUNCT7, IMM);
                q.push_back('{m[31:0], m[32], cyc});
            end
        end
    end

    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        FMT = f; OPCODE = op; RD = rd; RS1 = r1; RS2 = r2; FUNCT3 = f3; FUNCT7 = f7; IMM = imm;
    endtask

    function automatic logic [31:0] rand_imm();
        int v;
        case ($urandom_range(0, 3))
            0: v = int'($urandom);
            1: v = int'($urandom_range(0, 8191)) - 4096;
            2: v = int'($urandom & 32'hFFFFF000);
            default: v = int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20);
        endcase
        return v;
    endfunction

    task automatic drive_rand();
        drive(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom), 7'($urandom), rand_imm());
    endtask

    // Holds IN_VALID until accepted; returns just after the accepting edge.
    task automatic send();
        logic r;
        logic ok;
        ok = 1'b0;
        IN_VALID = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            r = IN_READY;
            @(posedge CLK);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept", ok, 1'b1);
    endtask

    task automatic directed(input string name, input logic [2:0] f, input logic [6:0] op,
                            input logic [4:0] rd, input logic [31:0] imm,
                            input logic [31:0] exp_ir, input logic exp_err);
        OUT_READY = 1'b1;
        drive(f, op, rd, 5'd0, 5'd0, 3'd0, 7'd0, imm);
        send();
        IN_VALID = 1'b0;
        @(posedge CLK);
        #1;
        chk({name, "_valid"}, OUT_VALID, 1'b1);
        chk({name, "_ir"}, IR, exp_ir);
        chk({name, "_err"}, ERR, exp_err);
    endtask

    initial begin
        int p0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", OUT_VALID, 1'b0);
        chk("rst_ir", IR, 32'h0);
        chk("rst_err", ERR, 1'b0);
        chk("rst_err_cnt", ERR_CNT, 0);
        chk("rst_in_ready", IN_READY, 1'b1);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        directed("i_type", 3'd1, 7'b0010011, 5'd1, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
        directed("b_type", 3'd3, 7'b1100011, 5'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
        directed("j_type", 3'd5, 7'b1101111, 5'd1, 32'h00000800, 32'h001000EF, 1'b0);
        directed("u_type", 3'd4, 7'b0110111, 5'd5, 32'h12345000, 32'h123452B7, 1'b0);
        directed("i_range", 3'd1, 7'b0010011, 5'd0, 32'h00000800, 32'h80000013, CHK);
        @(posedge CLK);
        #1;
        chk("cnt_after_i", ERR_CNT, CHK ? 1 : 0);
        directed("b_align", 3'd3, 7'b1100011, 5'd0, 32'h00000003, 32'h00000163, CHK);
        @(posedge CLK);
        #1;
        chk("cnt_after_b", ERR_CNT, CHK ? 2 : 0);
        directed("fmt7", 3'd7, 7'b0010011, 5'd3, 32'h00000005, 32'h00000000, 1'b1);
        @(posedge CLK);
        #1;
        chk("cnt_after_fmt7", ERR_CNT, CHK ? 3 : 0);

        // Backpressure: two words fill the pipe, third must stall.
        p0 = popped;
        OUT_READY = 1'b0;
        drive_rand(); send();
        drive_rand(); send();
        drive_rand();
        IN_VALID = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            chk("bp_in_ready", IN_READY, 1'b0);
        end
        @(posedge CLK);
        #1;
        OUT_READY = 1'b1;
        send();
        drive_rand(); send();
        IN_VALID = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (q.size() == 0) break;
        end
        chk("bp_delivered", popped - p0, 4);

        // Reset with two words in flight.
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        drive_rand(); send();
        drive_rand(); send();
        IN_VALID = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk("mid_rst_out_valid", OUT_VALID, 1'b0);
        chk("mid_rst_ir", IR, 32'h0);
        chk("mid_rst_err_cnt", ERR_CNT, 0);
        chk("mid_rst_in_ready", IN_READY, 1'b1);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        directed("post_rst", 3'd5, 7'b1101111, 5'd1, 32'h00000800, 32'h001000EF, 1'b0);

        // Randomized traffic with random stalls on both sides.
        for (int i = 0; i < 600; i++) begin
            @(posedge CLK);
            #1;
            drive_rand();
            IN_VALID  = ($urandom_range(0, 3) != 0);
            OUT_READY = ($urandom_range(0, 3) != 0);
        end
        @(posedge CLK);
        #1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        chk("drain_empty", q.size(), 0);
        chk("drain_out_valid", OUT_VALID, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
